// File: rtl/clk_tx_gen_if.sv
// Control and status bundle for the transmit clock generator.
// The bench drives through master; the generator attaches as slave.
interface clk_tx_gen_if #(
  parameter int RATE_COUNTER_WIDTH = 16,
  parameter int EDGE_COUNT_WIDTH   = 16
);
  logic                          clk_en;
  logic                          init_i;
  logic                          starting_polarity_i;
  logic                          enable_i;
  logic [RATE_COUNTER_WIDTH-1:0] high_rate_i;
  logic [RATE_COUNTER_WIDTH-1:0] low_rate_i;
  logic                          pause_en_i;
  logic                          pause_polarity_i;
  logic                          io_clk_pos_o;
  logic                          io_clk_neg_o;
  logic                          rise_o;
  logic                          fall_o;
  logic                          preemptive_rise_o;
  logic                          preemptive_fall_o;
  logic                          active_o;
  logic                          paused_o;
  logic                          config_error_o;
  logic [EDGE_COUNT_WIDTH-1:0]   edge_count_o;

  modport master (
    output clk_en, init_i, starting_polarity_i, enable_i,
           high_rate_i, low_rate_i, pause_en_i, pause_polarity_i,
    input  io_clk_pos_o, io_clk_neg_o, rise_o, fall_o,
           preemptive_rise_o, preemptive_fall_o,
           active_o, paused_o, config_error_o, edge_count_o
  );

  modport slave (
    input  clk_en, init_i, starting_polarity_i, enable_i,
           high_rate_i, low_rate_i, pause_en_i, pause_polarity_i,
    output io_clk_pos_o, io_clk_neg_o, rise_o, fall_o,
           preemptive_rise_o, preemptive_fall_o,
           active_o, paused_o, config_error_o, edge_count_o
  );
endinterface

// File: rtl/clk_tx_gen.sv
// Programmable differential clock generator: glitch-free high/low phases counted
// in clk_en cycles, with pause-at-level, edge pulses and a rising-edge counter.
module clk_tx_gen #(
  parameter int RATE_COUNTER_WIDTH = 16,
  parameter int EDGE_COUNT_WIDTH   = 16
) (
  input  logic         clk,
  input  logic         async_rst,
  clk_tx_gen_if.slave  bus
);
  localparam int RW = RATE_COUNTER_WIDTH;
  localparam int EW = EDGE_COUNT_WIDTH;
  localparam logic [RW-1:0] RATE_ONE = RW'(1);
  localparam logic [EW-1:0] EDGE_ONE = EW'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t          r_state;
  logic            r_level;
  logic            r_level_n;
  logic [RW-1:0]   r_cnt;
  logic [EW-1:0]   r_edge_cnt;
  logic            r_cfg_err;
  logic            r_rise;
  logic            r_fall;
  logic            r_rst_meta;
  logic            r_rst_sync;

  logic [RW-1:0]   w_rate_now;
  logic [RW-1:0]   w_rate_next;
  logic            w_hold_pause;
  logic            w_run_toggle;
  logic            w_pause_release;
  logic            w_toggle;

  // A zero rate would stall the counter; it runs as a one-cycle phase instead.
  function automatic logic [RW-1:0] load_value(input logic [RW-1:0] rate);
    return (rate == '0) ? '0 : (rate - RATE_ONE);
  endfunction

  assign w_rate_now      = r_level ? bus.high_rate_i : bus.low_rate_i;
  assign w_rate_next     = r_level ? bus.low_rate_i  : bus.high_rate_i;
  assign w_hold_pause    = bus.pause_en_i && (r_level == bus.pause_polarity_i);
  assign w_run_toggle    = (r_state == RUN) && (r_cnt == '0) &&
                           bus.enable_i && !w_hold_pause;
  assign w_pause_release = (r_state == PAUSED) && bus.enable_i && !bus.pause_en_i;
  assign w_toggle        = bus.clk_en && !bus.init_i &&
                           (w_run_toggle || w_pause_release);

  // Assert asynchronously, release two clocks later so no flop sees a runt release.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  always_ff @(posedge clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_state    <= IDLE;
      r_level    <= 1'b0;
      r_level_n  <= 1'b1;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_cfg_err  <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (bus.init_i) begin
        r_state    <= IDLE;
        r_level    <= bus.starting_polarity_i;
        r_level_n  <= ~bus.starting_polarity_i;
        r_cnt      <= '0;
        r_edge_cnt <= '0;
        r_cfg_err  <= 1'b0;
      end else if (bus.clk_en) begin
        if (w_toggle) begin
          r_state   <= RUN;
          r_level   <= ~r_level;
          r_level_n <= r_level;
          r_cnt     <= load_value(w_rate_next);
          if (w_rate_next == '0) r_cfg_err <= 1'b1;
          if (!r_level) begin
            r_rise     <= 1'b1;
            r_edge_cnt <= r_edge_cnt + EDGE_ONE;
          end else begin
            r_fall <= 1'b1;
          end
        end else begin
          case (r_state)
            IDLE: begin
              if (bus.enable_i) begin
                r_state <= RUN;
                r_cnt   <= load_value(w_rate_now);
                if (w_rate_now == '0) r_cfg_err <= 1'b1;
              end
            end
            RUN: begin
              if (r_cnt != '0)       r_cnt   <= r_cnt - RATE_ONE;
              else if (!bus.enable_i) r_state <= IDLE;
              else if (w_hold_pause)  r_state <= PAUSED;
            end
            PAUSED: begin
              if (!bus.enable_i) r_state <= IDLE;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.io_clk_pos_o      = r_level;
  assign bus.io_clk_neg_o      = r_level_n;
  assign bus.rise_o            = r_rise;
  assign bus.fall_o            = r_fall;
  assign bus.preemptive_rise_o = w_toggle && !r_level;
  assign bus.preemptive_fall_o = w_toggle && r_level;
  assign bus.active_o          = (r_state != IDLE);
  assign bus.paused_o          = (r_state == PAUSED);
  assign bus.config_error_o    = r_cfg_err;
  assign bus.edge_count_o      = r_edge_cnt;
endmodule

// File: tb/tb_clk_tx_gen.sv
// Directed bench for clk_tx_gen: phase timing, rate change, pause, clk_en gating,
// zero-rate error, edge-counter wrap and asynchronous reset.
module tb_clk_tx_gen;
  localparam int RW = 16;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic async_rst;
  int   n_vec = 0;
  int   n_err = 0;

  int exp2[17] = '{0,0,0,0,0,1,1,1,0,0,0,0,0,1,1,0,0};
  int exp3[13] = '{0,0,0,0,0,1,1,1,0,0,0,0,0};

  clk_tx_gen_if #(.RATE_COUNTER_WIDTH(RW), .EDGE_COUNT_WIDTH(EW)) bus();

  clk_tx_gen #(.RATE_COUNTER_WIDTH(RW), .EDGE_COUNT_WIDTH(EW)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bus.slave)
  );

  initial forever #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic pol);
    bus.starting_polarity_i = pol;
    bus.init_i = 1'b1;
    step();
    bus.init_i = 1'b0;
  endtask

  initial begin
    async_rst               = 1'b1;
    bus.clk_en              = 1'b1;
    bus.init_i              = 1'b0;
    bus.starting_polarity_i = 1'b0;
    bus.enable_i            = 1'b0;
    bus.high_rate_i         = 16'd4;
    bus.low_rate_i          = 16'd4;
    bus.pause_en_i          = 1'b0;
    bus.pause_polarity_i    = 1'b0;
    repeat (3) step();
    check("rst_pos", bus.io_clk_pos_o, 0);
    check("rst_neg", bus.io_clk_neg_o, 1);
    check("rst_edge", bus.edge_count_o, 0);
    check("rst_active", bus.active_o, 0);
    check("rst_err", bus.config_error_o, 0);
    async_rst = 1'b0;
    repeat (3) step();
    check("idle_wait_enable", bus.active_o, 0);

    // 4/4 free-running clock
    do_init(1'b0);
    bus.enable_i = 1'b1;
    step();
    for (int k = 0; k < 24; k++) begin
      check("t1_pos", bus.io_clk_pos_o, (k / 4) % 2);
      check("t1_neg", bus.io_clk_neg_o, 1 - ((k / 4) % 2));
      check("t1_rise", bus.rise_o, (k % 8 == 4) ? 1 : 0);
      check("t1_fall", bus.fall_o, (k % 8 == 0 && k > 0) ? 1 : 0);
      check("t1_prise", bus.preemptive_rise_o, (k % 8 == 3) ? 1 : 0);
      check("t1_pfall", bus.preemptive_fall_o, (k % 8 == 7) ? 1 : 0);
      check("t1_active", bus.active_o, 1);
      step();
    end
    check("t1_edge_cnt", bus.edge_count_o, 3);

    // mid-phase rate change applies at the next boundary
    bus.high_rate_i = 16'd3;
    bus.low_rate_i  = 16'd5;
    do_init(1'b0);
    step();
    for (int k = 0; k < 17; k++) begin
      check("t2_pos", bus.io_clk_pos_o, exp2[k]);
      if (k == 6) bus.high_rate_i = 16'd2;
      step();
    end

    // pause at low requested during high phase
    bus.high_rate_i = 16'd3;
    bus.low_rate_i  = 16'd5;
    do_init(1'b0);
    step();
    for (int k = 0; k < 13; k++) begin
      check("t3_pos", bus.io_clk_pos_o, exp3[k]);
      check("t3_paused", bus.paused_o, 0);
      if (k == 7)  check("t3_pfall", bus.preemptive_fall_o, 1);
      if (k == 12) check("t3_no_prise", bus.preemptive_rise_o, 0);
      if (k == 6) begin
        bus.pause_en_i       = 1'b1;
        bus.pause_polarity_i = 1'b0;
      end
      step();
    end
    for (int k = 13; k < 16; k++) begin
      check("t3_park_pos", bus.io_clk_pos_o, 0);
      check("t3_park_paused", bus.paused_o, 1);
      check("t3_park_active", bus.active_o, 1);
      check("t3_park_rise", bus.rise_o, 0);
      if (k < 15) step();
    end
    bus.pause_en_i = 1'b0;
    #1;
    check("t3_rel_prise", bus.preemptive_rise_o, 1);
    step();
    check("t3_rel_rise", bus.rise_o, 1);
    check("t3_rel_pos", bus.io_clk_pos_o, 1);
    check("t3_rel_paused", bus.paused_o, 0);
    check("t3_rel_edge", bus.edge_count_o, 2);

    // clk_en every other cycle doubles the period
    bus.high_rate_i = 16'd4;
    bus.low_rate_i  = 16'd4;
    do_init(1'b0);
    step();
    for (int j = 0; j < 40; j++) begin
      check("t4_pos", bus.io_clk_pos_o, ((j / 2) / 4) % 2);
      check("t4_rise", bus.rise_o, (j % 2 == 0 && (j / 2) % 8 == 4) ? 1 : 0);
      check("t4_fall", bus.fall_o, (j % 2 == 0 && (j / 2) % 8 == 0 && j > 0) ? 1 : 0);
      bus.clk_en = ((j + 1) % 2 == 0);
      #1;
      check("t4_prise", bus.preemptive_rise_o,
            ((j + 1) % 2 == 0 && ((j + 1) / 2) % 8 == 4) ? 1 : 0);
      step();
    end
    check("t4_edge_cnt", bus.edge_count_o, 3);
    bus.clk_en = 1'b1;

    // zero low rate: one-cycle low phases, sticky error
    bus.high_rate_i = 16'd2;
    bus.low_rate_i  = 16'd0;
    do_init(1'b0);
    step();
    for (int k = 0; k < 9; k++) begin
      check("t5_pos", bus.io_clk_pos_o, (k % 3 != 0) ? 1 : 0);
      check("t5_err", bus.config_error_o, 1);
      step();
    end
    bus.low_rate_i = 16'd4;
    repeat (4) step();
    check("t5_err_sticky", bus.config_error_o, 1);
    bus.starting_polarity_i = 1'b1;
    bus.init_i = 1'b1;
    #1;
    check("t5_init_no_prise", bus.preemptive_rise_o, 0);
    check("t5_init_no_pfall", bus.preemptive_fall_o, 0);
    step();
    bus.init_i = 1'b0;
    check("t5_err_clear", bus.config_error_o, 0);
    check("t5_init_pos", bus.io_clk_pos_o, 1);
    check("t5_init_neg", bus.io_clk_neg_o, 0);
    check("t5_init_edge", bus.edge_count_o, 0);
    check("t5_init_idle", bus.active_o, 0);

    // 8-bit edge counter wraps after 256 rises
    bus.high_rate_i = 16'd1;
    bus.low_rate_i  = 16'd1;
    do_init(1'b0);
    step();
    for (int k = 0; k < 512; k++) begin
      if (k == 1 || k == 509 || k == 511) begin
        check("t6_edge", bus.edge_count_o, ((k + 1) / 2) % 256);
        check("t6_pos", bus.io_clk_pos_o, 1);
      end
      step();
    end

    // async reset with the clock stopped
    bus.high_rate_i = 16'd4;
    bus.low_rate_i  = 16'd4;
    do_init(1'b0);
    step();
    repeat (5) step();
    check("t7_pre_pos", bus.io_clk_pos_o, 1);
    check("t7_pre_edge", bus.edge_count_o, 1);
    clk_run = 1'b0;
    #20;
    async_rst = 1'b1;
    #1;
    check("t7_rst_pos", bus.io_clk_pos_o, 0);
    check("t7_rst_neg", bus.io_clk_neg_o, 1);
    check("t7_rst_edge", bus.edge_count_o, 0);
    check("t7_rst_active", bus.active_o, 0);
    check("t7_rst_rise", bus.rise_o, 0);
    clk_run = 1'b1;
    step();
    async_rst = 1'b0;
    step();
    check("t7_sync_a", bus.active_o, 0);
    step();
    check("t7_sync_b", bus.active_o, 0);
    step();
    check("t7_run", bus.active_o, 1);
    check("t7_run_pos", bus.io_clk_pos_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
